uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_arbiter_rr_picker.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_t   : arbiter FSM state encoding
//   TIMEOUT_LIMIT : cycles WAIT_BUSY may see tx_busy low before the frame is
//                   abandoned (only used when UART_TX_ARB_TIMEOUT_EN is defined)
package uart_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } arb_state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
//   req_valid  in  : pending requests, one bit per requester
//   last_grant in  : index of the most recently granted requester
//   winner     out : first valid index at or after last_grant+1, with wrap
//   found      out : at least one request is valid
module rr_picker #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req_valid,
   input  logic [ID_WIDTH-1:0] last_grant,
   output logic [ID_WIDTH-1:0] winner,
   output logic                found
);

   logic [ID_WIDTH-1:0] start;
   logic [NUM_REQ-1:0]  rot;

   assign start = (last_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : last_grant + 1'b1;

   // Rotate so the search start sits at bit 0; a plain priority encode then
   // gives the offset from start.
   assign rot = NUM_REQ'({req_valid, req_valid} >> start);

   always_comb begin
      int pos;
      found = 1'b0;
      pos   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            pos   = k;
         end
      end
      pos = pos + int'(start);
      if (pos >= NUM_REQ) begin
         pos = pos - NUM_REQ;
      end
      winner = ID_WIDTH'(pos);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ requesters,
// round-robin, one frame at a time.
//   CLK, RST        : clock, asynchronous active-low reset
//   req_valid/data/par_en/par_typ : per-requester byte and parity settings
//   req_ready       : one-cycle pulse to the requester whose byte was taken
//   tx_p_data, tx_data_valid, tx_par_en, tx_par_typ : to the transmitter
//   tx_busy         : transmitter busy
//   grant_id        : owner of the current frame
//   arb_busy        : arbiter is not idle
//   timeout_err     : (UART_TX_ARB_TIMEOUT_EN only) transmitter never went busy
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | free; grants when a request is pending and tx_busy low
// ST_LAUNCH    | one cycle: tx_data_valid and req_ready[winner] asserted
// ST_WAIT_BUSY | waiting for the transmitter to pick up the byte
// ST_WAIT_DONE | transmitter busy; return to idle when it drops
module uart_tx_arbiter
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_par_en,
   input  logic [NUM_REQ-1:0]            req_par_typ,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         tx_p_data,
   output logic                          tx_data_valid,
   output logic                          tx_par_en,
   output logic                          tx_par_typ,
   input  logic                          tx_busy,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          arb_busy
`ifdef UART_TX_ARB_TIMEOUT_EN
   ,
   output logic                          timeout_err
`endif
);

   arb_state_t          state_q, state_d;
   logic [ID_WIDTH-1:0] last_grant_q;
   logic [ID_WIDTH-1:0] winner;
   logic                found;
   logic                capture;
   logic                tmo_hit;
   logic [NUM_REQ-1:0]  win_onehot;
   logic [DATA_WIDTH-1:0] win_data;
   logic                win_par_en;
   logic                win_par_typ;

   rr_picker #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_picker (
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .winner     (winner),
      .found      (found)
   );

   assign win_onehot  = NUM_REQ'(1) << winner;
   assign win_data    = DATA_WIDTH'(req_data >> (int'(winner) * DATA_WIDTH));
   assign win_par_en  = |(req_par_en & win_onehot);
   assign win_par_typ = |(req_par_typ & win_onehot);

`ifdef UART_TX_ARB_TIMEOUT_EN
   // Down-counter loaded in LAUNCH; terminal count in WAIT_BUSY with tx_busy
   // still low marks the 255th idle cycle.
   logic [7:0] tmo_cnt_q;

   assign tmo_hit = (state_q == ST_WAIT_BUSY) && !tx_busy && (tmo_cnt_q == '0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tmo_cnt_q   <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= tmo_hit;
         if (state_q == ST_LAUNCH) begin
            tmo_cnt_q <= TIMEOUT_LIMIT - 8'd1;
         end else if ((state_q == ST_WAIT_BUSY) && !tx_busy && (tmo_cnt_q != '0)) begin
            tmo_cnt_q <= tmo_cnt_q - 8'd1;
         end
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      capture       = 1'b0;
      tx_data_valid = 1'b0;
      req_ready     = '0;
      arb_busy      = (state_q != ST_IDLE);
      unique case (state_q)
         ST_IDLE: begin
            if (found && !tx_busy) begin
               state_d = ST_LAUNCH;
               capture = 1'b1;
            end
         end
         ST_LAUNCH: begin
            tx_data_valid = 1'b1;
            req_ready     = NUM_REQ'(1) << grant_id;
            state_d       = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (tmo_hit) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= ST_IDLE;
         last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
         tx_p_data    <= '0;
         tx_par_en    <= 1'b0;
         tx_par_typ   <= 1'b0;
         grant_id     <= '0;
      end else begin
         state_q <= state_d;
         // Captured once on selection so a requester dropping req_valid
         // later cannot disturb the frame in flight.
         if (capture) begin
            tx_p_data  <= win_data;
            tx_par_en  <= win_par_en;
            tx_par_typ <= win_par_typ;
            grant_id   <= winner;
         end
         if (state_q == ST_LAUNCH) begin
            last_grant_q <= grant_id;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]  req_par_en = '0;
   logic [N-1:0]  req_par_typ = '0;
   logic [N-1:0]  req_ready;
   logic [DW-1:0] tx_p_data;
   logic          tx_data_valid;
   logic          tx_par_en;
   logic          tx_par_typ;
   logic          tx_busy = 1'b0;
   logic [IW-1:0] grant_id;
   logic          arb_busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
   logic          timeout_err;
   int            tmo_at;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(IW)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_par_en    (req_par_en),
      .req_par_typ   (req_par_typ),
      .req_ready     (req_ready),
      .tx_p_data     (tx_p_data),
      .tx_data_valid (tx_data_valid),
      .tx_par_en     (tx_par_en),
      .tx_par_typ    (tx_par_typ),
      .tx_busy       (tx_busy),
      .grant_id      (grant_id),
      .arb_busy      (arb_busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
      ,
      .timeout_err   (timeout_err)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference round-robin: first valid index after 'last', wrapping.
   function automatic int rr_next(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_tx_data_valid"}, tx_data_valid, 0);
      chk({tag, "_tx_p_data"}, tx_p_data, 0);
      chk({tag, "_tx_par_en"}, tx_par_en, 0);
      chk({tag, "_tx_par_typ"}, tx_par_typ, 0);
      chk({tag, "_grant_id"}, grant_id, 0);
      chk({tag, "_arb_busy"}, arb_busy, 0);
   endtask

   // Called on the launch negedge; keeps tx_busy high 'len' cycles (len >= 2
   // so WAIT_BUSY sees it) and returns on the first idle negedge.
   task automatic finish_frame(input int len);
      int c;
      tx_busy = 1'b1;
      repeat (len) @(negedge CLK);
      tx_busy = 1'b0;
      c = 0;
      @(negedge CLK);
      while (arb_busy && c < 8) begin
         @(negedge CLK);
         c++;
      end
      chk("frame_end_idle", arb_busy, 0);
   endtask

   typedef struct {
      logic [N-1:0]  valid;
      logic [N-1:0]  pe;
      logic [N-1:0]  pt;
      int            exp_id;
      logic [DW-1:0] exp_data;
      logic          exp_pe;
      logic          exp_pt;
   } vec_t;

   vec_t vecs [10];

   // random-phase state
   bit            p_valid [N];
   logic [DW-1:0] p_data  [N];
   bit            p_pe    [N];
   bit            p_pt    [N];
   int            ph;        // 0 free, 1 launch cycle, 2 awaiting busy, 3 awaiting release
   int            m_last, m_win;
   logic [DW-1:0] m_data;
   bit            m_pe, m_pt;
   int            dly, len;
   logic [N-1:0]  served;
   logic [N-1:0]  exp_ready;

   initial begin
      vecs[0] = '{4'b0001, 4'b0001, 4'b0000, 0, 8'hA5, 1'b1, 1'b0};
      vecs[1] = '{4'b1111, 4'b0010, 4'b0010, 1, 8'hB1, 1'b1, 1'b1};
      vecs[2] = '{4'b1111, 4'b0000, 4'b0100, 2, 8'hC2, 1'b0, 1'b1};
      vecs[3] = '{4'b1111, 4'b1000, 4'b0000, 3, 8'hD3, 1'b1, 1'b0};
      vecs[4] = '{4'b1111, 4'b1111, 4'b1111, 0, 8'hA5, 1'b1, 1'b1};
      vecs[5] = '{4'b1010, 4'b0000, 4'b0000, 1, 8'hB1, 1'b0, 1'b0};
      vecs[6] = '{4'b1010, 4'b1000, 4'b1000, 3, 8'hD3, 1'b1, 1'b1};
      vecs[7] = '{4'b0100, 4'b0100, 4'b0000, 2, 8'hC2, 1'b1, 1'b0};
      vecs[8] = '{4'b0011, 4'b0001, 4'b0001, 0, 8'hA5, 1'b1, 1'b1};
      vecs[9] = '{4'b1000, 4'b1000, 4'b1000, 3, 8'hD3, 1'b1, 1'b1};

      // reset state
      repeat (2) @(negedge CLK);
      chk_reset_outputs("reset");
      RST = 1'b1;
      @(negedge CLK);

      // table: round-robin order, captured data/parity, busy hold-off
      req_data = 32'hD3C2B1A5;
      for (int v = 0; v < 10; v++) begin
         req_valid   = vecs[v].valid;
         req_par_en  = vecs[v].pe;
         req_par_typ = vecs[v].pt;
         tx_busy     = 1'b0;
         @(negedge CLK);
         exp_ready = '0;
         exp_ready[vecs[v].exp_id] = 1'b1;
         chk($sformatf("v%0d_launch", v), tx_data_valid, 1);
         chk($sformatf("v%0d_req_ready", v), req_ready, exp_ready);
         chk($sformatf("v%0d_grant_id", v), grant_id, vecs[v].exp_id);
         chk($sformatf("v%0d_tx_p_data", v), tx_p_data, vecs[v].exp_data);
         chk($sformatf("v%0d_tx_par_en", v), tx_par_en, vecs[v].exp_pe);
         chk($sformatf("v%0d_tx_par_typ", v), tx_par_typ, vecs[v].exp_pt);
         tx_busy = 1'b1;
         for (int c = 0; c < 11; c++) begin
            @(negedge CLK);
            chk($sformatf("v%0d_busy_no_launch", v), tx_data_valid, 0);
            chk($sformatf("v%0d_busy_no_ready", v), req_ready, 0);
            chk($sformatf("v%0d_busy_hold", v), tx_p_data, vecs[v].exp_data);
            chk($sformatf("v%0d_busy_arb_busy", v), arb_busy, 1);
         end
         tx_busy = 1'b0;
         @(negedge CLK);
         chk($sformatf("v%0d_gap_idle", v), arb_busy, 0);
         chk($sformatf("v%0d_gap_no_launch", v), tx_data_valid, 0);
      end
      req_valid = '0;

      // external tx_busy in idle blocks granting (last grant 3)
      req_valid = 4'b0010;
      tx_busy   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         chk("ext_busy_no_launch", tx_data_valid, 0);
         chk("ext_busy_idle", arb_busy, 0);
      end
      tx_busy = 1'b0;
      @(negedge CLK);
      chk("ext_busy_release_launch", tx_data_valid, 1);
      chk("ext_busy_release_grant", grant_id, 1);
      req_valid = '0;
      finish_frame(3);

      // req_valid dropped after selection (last grant 1)
      req_valid   = 4'b0100;
      req_data    = 32'h0077_0000;
      req_par_en  = 4'b0100;
      req_par_typ = 4'b0100;
      @(negedge CLK);
      chk("drop_launch", tx_data_valid, 1);
      chk("drop_grant", grant_id, 2);
      chk("drop_data", tx_p_data, 8'h77);
      req_valid   = '0;
      req_data    = '1;
      req_par_en  = '0;
      req_par_typ = '0;
      tx_busy     = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         chk("drop_hold_data", tx_p_data, 8'h77);
         chk("drop_hold_par", {tx_par_en, tx_par_typ}, 2'b11);
      end
      tx_busy = 1'b0;
      @(negedge CLK);
      chk("drop_end_idle", arb_busy, 0);

      // reset during WAIT_DONE (last grant 2)
      req_valid   = 4'b1111;
      req_data    = 32'hD3C2B1A5;
      req_par_en  = 4'b1111;
      req_par_typ = 4'b0000;
      @(negedge CLK);
      chk("rst_mid_launch_grant", grant_id, 3);
      tx_busy = 1'b1;
      repeat (2) @(negedge CLK);
      chk("rst_mid_in_frame", arb_busy, 1);
      #2 RST = 1'b0;
      #1 chk_reset_outputs("rst_mid_async");
      @(negedge CLK);
      chk("rst_mid_no_ready", req_ready, 0);
      tx_busy = 1'b0;
      RST     = 1'b1;
      @(negedge CLK);
      chk("rst_after_launch", tx_data_valid, 1);
      chk("rst_after_grant0", grant_id, 0);
      chk("rst_after_ready", req_ready, 4'b0001);
      chk("rst_after_data", tx_p_data, 8'hA5);
      req_valid = '0;
      finish_frame(3);

`ifdef UART_TX_ARB_TIMEOUT_EN
      // transmitter never goes busy
      req_valid = 4'b0001;
      tx_busy   = 1'b0;
      @(negedge CLK);
      chk("tmo_launch", tx_data_valid, 1);
      req_valid = '0;
      tmo_at = 0;
      for (int c = 1; c <= 300 && tmo_at == 0; c++) begin
         @(negedge CLK);
         if (timeout_err) tmo_at = c;
      end
      chk("tmo_cycle", tmo_at, 256);
      chk("tmo_idle", arb_busy, 0);
      @(negedge CLK);
      chk("tmo_one_cycle", timeout_err, 0);
`endif

      // randomized traffic against the reference model
      req_valid = '0;
      tx_busy   = 1'b0;
      RST       = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < N; i++) begin
         p_valid[i] = 1'b0;
         p_data[i]  = '0;
         p_pe[i]    = 1'b0;
         p_pt[i]    = 1'b0;
      end
      ph = 0; m_last = N - 1; m_win = 0; m_data = '0; m_pe = 0; m_pt = 0;
      dly = 0; len = 0; served = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) p_valid[i] = 1'b0;
            if (!p_valid[i] && $urandom_range(0, 3) == 0) begin
               p_valid[i] = 1'b1;
               p_data[i]  = DW'($urandom);
               p_pe[i]    = 1'($urandom);
               p_pt[i]    = 1'($urandom);
            end else if (p_valid[i] && $urandom_range(0, 31) == 0) begin
               p_valid[i] = 1'b0;
            end
         end
         if (tx_data_valid) begin
            dly = $urandom_range(0, 2);
            len = $urandom_range(1, 12);
            tx_busy = 1'b0;
         end else if (dly > 0) begin
            dly--;
            tx_busy = 1'b0;
         end else if (len > 0) begin
            len--;
            tx_busy = 1'b1;
         end else begin
            tx_busy = (ph == 0) && ($urandom_range(0, 15) == 0);
         end
         for (int i = 0; i < N; i++) begin
            req_valid[i]           = p_valid[i];
            req_data[i*DW +: DW]   = p_data[i];
            req_par_en[i]          = p_pe[i];
            req_par_typ[i]         = p_pt[i];
         end

         case (ph)
            0: if (req_valid != 0 && !tx_busy) begin
                  m_win  = rr_next(req_valid, m_last);
                  m_last = m_win;
                  m_data = p_data[m_win];
                  m_pe   = p_pe[m_win];
                  m_pt   = p_pt[m_win];
                  served[m_win] = 1'b1;
                  ph = 1;
               end
            1: ph = 2;
            2: if (tx_busy) ph = 3;
            default: if (!tx_busy) ph = 0;
         endcase

         @(negedge CLK);
         exp_ready = '0;
         if (ph == 1) exp_ready[m_win] = 1'b1;
         chk("rnd_arb_busy", arb_busy, (ph != 0));
         chk("rnd_tx_data_valid", tx_data_valid, (ph == 1));
         chk("rnd_req_ready", req_ready, exp_ready);
         if (ph != 0) begin
            chk("rnd_grant_id", grant_id, m_win);
            chk("rnd_tx_p_data", tx_p_data, m_data);
            chk("rnd_par", {tx_par_en, tx_par_typ}, {m_pe, m_pt});
         end
      end
      chk("rnd_all_served", served, 4'b1111);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
